// File: rtl/rv16_run_ctrl.sv
// rv16_run_ctrl -- run controller and register-trace monitor for the rv16r core.
//
// Sequences the core's reset and run window, ends the run on a core halt or
// when the cycle budget is used up, and (optionally) records every change on
// the watched register buses into a timestamped trace FIFO.
//
// Build option:
//   RV16_RUN_CTRL_TRACE_EN  defined     -> snapshot, compare and trace FIFO built
//                           not defined -> trace outputs tied to 0, ev_ready ignored
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (accepted in IDLE or DONE)
//   halt            core halt indication (sampled in RUN)
//   watch           CHANNELS x WIDTH watched buses, channel i at [i*WIDTH +: WIDTH]
//   core_rst        reset to the core (high in IDLE and RESET)
//   core_en         run enable to the core (high in RUN)
//   busy / done     high in RESET,RUN / high in DONE
//   timed_out       in DONE: 1 = budget expired, 0 = halted
//   cycles          run cycles completed in the current or last run
//   ev_valid/ready  trace FIFO head handshake
//   ev_mask         channels that changed in the head entry
//   ev_data         all channel values at the change
//   ev_cycle        value of cycles when the change was sampled
//   ev_overflow     sticky: an entry was dropped because the FIFO was full
//
// States:
//   state   | meaning
//   S_IDLE  | after reset, core held in reset, waiting for start
//   S_RESET | core held in reset for RESET_CYCLES+1 cycles, snapshot tracks watch
//   S_RUN   | core enabled, cycles counting, changes traced
//   S_DONE  | run ended (halt or budget), waiting for start

module rv16_run_ctrl #(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 3,
    parameter int RESET_CYCLES = 5,
    parameter int MAX_CYCLES   = 250,
    parameter int CNT_W        = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      halt,
    input  logic [CHANNELS*WIDTH-1:0] watch,
    output logic                      core_rst,
    output logic                      core_en,
    output logic                      busy,
    output logic                      done,
    output logic                      timed_out,
    output logic [CNT_W-1:0]          cycles,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [CHANNELS-1:0]       ev_mask,
    output logic [CHANNELS*WIDTH-1:0] ev_data,
    output logic [CNT_W-1:0]          ev_cycle,
    output logic                      ev_overflow
);

    localparam int RST_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [RST_W-1:0] rst_cnt;
    logic             start_ok;
    logic             budget_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        core_rst   = 1'b1;
        core_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_ok   = 1'b0;
        // Last budgeted RUN cycle: cycles reaches MAX_CYCLES at this edge.
        budget_hit = (cycles == CNT_W'(MAX_CYCLES - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = S_RESET;
                end
            end
            S_RESET: begin
                busy = 1'b1;
                if (rst_cnt == '0) state_nxt = S_RUN;
            end
            S_RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
                busy     = 1'b1;
                if (halt || budget_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = S_RESET;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset down-counter, run-cycle counter and termination cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt   <= '0;
            cycles    <= '0;
            timed_out <= 1'b0;
        end else begin
            if (start_ok) begin
                rst_cnt   <= RST_W'(RESET_CYCLES);
                cycles    <= '0;
                timed_out <= 1'b0;
            end else if (state == S_RESET && rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            if (state == S_RUN) begin
                cycles <= cycles + 1'b1;
                // Halt takes priority over a simultaneous budget expiry.
                if (!halt && budget_hit) timed_out <= 1'b1;
            end
        end
    end

`ifdef RV16_RUN_CTRL_TRACE_EN

    localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

    logic [CHANNELS*WIDTH-1:0] snap;
    logic [CHANNELS-1:0]       chg;
    logic [CHANNELS-1:0]       mask_mem [FIFO_DEPTH];
    logic [CHANNELS*WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]          cyc_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      full, pop, push, change;

    always_comb begin
        chg = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            chg[i] = (watch[i*WIDTH +: WIDTH] != snap[i*WIDTH +: WIDTH]);
        end
    end

    assign change = (state == S_RUN) && (chg != '0);
    assign full   = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop    = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push   = change && (!full || pop);

    // Snapshot follows watch through RESET so the first RUN cycle compares
    // against the value present while the core was still held in reset.
    always_ff @(posedge clk) begin
        if (rst)                                    snap <= '0;
        else if (state == S_RESET || state == S_RUN) snap <= watch;
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (change && full && !pop) ev_overflow <= 1'b1;
        end
    end

    // Storage needs no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= chg;
            data_mem[wr_ptr] <= watch;
            cyc_mem[wr_ptr]  <= cycles;
        end
    end

    assign ev_valid = (count != '0);
    assign ev_mask  = mask_mem[rd_ptr];
    assign ev_data  = data_mem[rd_ptr];
    assign ev_cycle = cyc_mem[rd_ptr];

`else

    logic unused_trace;

    assign unused_trace = ^{watch, ev_ready, 1'(FIFO_DEPTH)};
    assign ev_valid     = 1'b0;
    assign ev_mask      = '0;
    assign ev_data      = '0;
    assign ev_cycle     = '0;
    assign ev_overflow  = 1'b0;

`endif

endmodule

// File: tb/tb_rv16_run_ctrl.sv
// Self-checking bench for rv16_run_ctrl. Inputs change 1 time unit after a
// rising edge; outputs are sampled there or on the falling edge. A scoreboard
// queue holds the trace entries the bench expects the FIFO to deliver, in order.
module tb_rv16_run_ctrl;

    localparam int WIDTH        = 16;
    localparam int CHANNELS     = 3;
    localparam int RESET_CYCLES = 5;
    localparam int MAX_CYCLES   = 20;
    localparam int CNT_W        = 16;
    localparam int FIFO_DEPTH   = 8;
    localparam int DW           = WIDTH * CHANNELS;

`ifdef RV16_RUN_CTRL_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst, start, halt, ev_ready;
    logic [DW-1:0]       watch;
    logic                core_rst, core_en, busy, done, timed_out;
    logic [CNT_W-1:0]    cycles;
    logic                ev_valid, ev_overflow;
    logic [CHANNELS-1:0] ev_mask;
    logic [DW-1:0]       ev_data;
    logic [CNT_W-1:0]    ev_cycle;

    always #5 clk = ~clk;

    rv16_run_ctrl #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .watch(watch),
        .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
        .timed_out(timed_out), .cycles(cycles), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_mask(ev_mask), .ev_data(ev_data),
        .ev_cycle(ev_cycle), .ev_overflow(ev_overflow)
    );

    typedef struct packed {
        logic [CHANNELS-1:0] mask;
        logic [DW-1:0]       data;
        logic [CNT_W-1:0]    cyc;
    } ev_t;

    ev_t           sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            m_phase;   // 0 idle/done, 1 reset, 2 run
    int            m_k;       // model of cycles
    logic          m_ov;
    logic [DW-1:0] m_snap;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [CHANNELS-1:0] diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) r[i] = (a[i*WIDTH +: WIDTH] != b[i*WIDTH +: WIDTH]);
        return r;
    endfunction

    // One clock: scoreboard step on the falling edge, then the rising edge.
    task automatic tick();
        ev_t                 e;
        logic [CHANNELS-1:0] m;
        bit                  full_m, pop_m;
        @(negedge clk);
        check("ev_valid", 64'(ev_valid), 64'(sb.size() != 0));
        check("ev_overflow", 64'(ev_overflow), 64'(m_ov));
        full_m = (sb.size() == FIFO_DEPTH);
        pop_m  = (sb.size() != 0) && ev_ready;
        if (pop_m) begin
            e = sb.pop_front();
            check("ev_mask", 64'(ev_mask), 64'(e.mask));
            check("ev_data", 64'(ev_data), 64'(e.data));
            check("ev_cycle", 64'(ev_cycle), 64'(e.cyc));
        end
        if (m_phase == 2) begin
            m = diff(watch, m_snap);
            if (TRACE && m != '0) begin
                if (full_m && !pop_m) begin
                    m_ov = 1'b1;
                end else begin
                    e.mask = m;
                    e.data = watch;
                    e.cyc  = CNT_W'(m_k);
                    sb.push_back(e);
                end
            end
        end
        if (m_phase == 1 || m_phase == 2) m_snap = watch;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_ov    = 1'b0;
            m_phase = 0;
            m_k     = 0;
        end
    endtask

    task automatic reset_checks();
        check("r_core_rst", 64'(core_rst), 64'(1));
        check("r_core_en", 64'(core_en), 64'(0));
        check("r_busy", 64'(busy), 64'(0));
        check("r_done", 64'(done), 64'(0));
        check("r_timed_out", 64'(timed_out), 64'(0));
        check("r_cycles", 64'(cycles), 64'(0));
        check("r_ev_valid", 64'(ev_valid), 64'(0));
        check("r_ev_overflow", 64'(ev_overflow), 64'(0));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.delete();
        m_ov    = 1'b0;
        m_phase = 1;
        m_k     = 0;
        check("st_cycles", 64'(cycles), 64'(0));
        check("st_timed_out", 64'(timed_out), 64'(0));
        check("st_done", 64'(done), 64'(0));
        check("st_flush", 64'(ev_valid), 64'(0));
        check("st_overflow", 64'(ev_overflow), 64'(0));
        for (int i = 0; i <= RESET_CYCLES; i++) begin
            check("rs_core_rst", 64'(core_rst), 64'(1));
            check("rs_core_en", 64'(core_en), 64'(0));
            check("rs_busy", 64'(busy), 64'(1));
            tick();
        end
        m_phase = 2;
        check("run_core_rst", 64'(core_rst), 64'(0));
        check("run_core_en", 64'(core_en), 64'(1));
    endtask

    task automatic run_cycle(input logic [DW-1:0] w, input logic h);
        watch = w;
        halt  = h;
        tick();
        halt = 1'b0;
        m_k++;
        check("cycles", 64'(cycles), 64'(m_k));
        if (h || m_k == MAX_CYCLES) begin
            m_phase = 0;
            check("end_done", 64'(done), 64'(1));
            check("end_timed_out", 64'(timed_out), 64'(!h));
            check("end_core_en", 64'(core_en), 64'(0));
            check("end_core_rst", 64'(core_rst), 64'(0));
            check("end_busy", 64'(busy), 64'(0));
        end else begin
            check("run_busy", 64'(busy), 64'(1));
            check("run_en", 64'(core_en), 64'(1));
            check("run_done", 64'(done), 64'(0));
        end
    endtask

    initial begin
        logic [DW-1:0] base, w;
        rst = 1'b1; start = 1'b0; halt = 1'b0; ev_ready = 1'b0; watch = '0;
        m_phase = 0; m_k = 0; m_ov = 1'b0; m_snap = '0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        reset_checks();

        // Basic run: halt on the 10th RUN cycle.
        do_start();
        for (int k = 0; k < 10; k++) run_cycle(watch, k == 9);

        // Budget expiry, then halt coinciding with the last budgeted cycle.
        do_start();
        for (int k = 0; k < MAX_CYCLES; k++) run_cycle(watch, 1'b0);
        tick();
        check("done_hold_cycles", 64'(cycles), 64'(MAX_CYCLES));
        check("done_hold", 64'(done), 64'(1));
        do_start();
        for (int k = 0; k < MAX_CYCLES; k++) run_cycle(watch, k == MAX_CYCLES - 1);

        // Trace content: ch1 at cycles=3, ch0+ch2 at cycles=7.
        ev_ready = 1'b1;
        do_start();
        for (int k = 0; k < 10; k++) begin
            w = '0;
            if (k >= 3) w[WIDTH +: WIDTH] = 16'h0005;
            if (k >= 7) begin
                w[0 +: WIDTH]       = 16'h1111;
                w[2*WIDTH +: WIDTH] = 16'h2222;
            end
            run_cycle(w, k == 9);
        end
        tick();
        tick();
        check("trace_left", 64'(sb.size()), 64'(0));

        // Overflow: ready low, ch0 toggles for 10 cycles; drain in RUN then DONE.
        ev_ready = 1'b0;
        base = watch;
        do_start();
        for (int k = 0; k < 10; k++) run_cycle(base ^ DW'((k % 2 == 0) ? 1 : 0), 1'b0);
        check("ovf_flag", 64'(ev_overflow), 64'(m_ov));
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) run_cycle(base, 1'b0);
        run_cycle(base, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        check("ovf_left", 64'(sb.size()), 64'(0));

        // Full boundary: push and pop in the same cycle while full.
        ev_ready = 1'b0;
        do_start();
        for (int k = 0; k < 8; k++) run_cycle(base ^ DW'((k % 2 == 0) ? 2 : 0), 1'b0);
        ev_ready = 1'b1;
        run_cycle(base ^ DW'(2), 1'b0);
        ev_ready = 1'b0;
        run_cycle(base ^ DW'(2), 1'b0);
        check("full_no_ovf", 64'(ev_overflow), 64'(0));
        run_cycle(base ^ DW'(2), 1'b1);

        // Restart with a full FIFO flushes; start in RUN ignored; rst at RUN cycle 4.
        do_start();
        run_cycle(base ^ DW'(4), 1'b0);
        run_cycle(base ^ DW'(4), 1'b0);
        start = 1'b1;
        run_cycle(base ^ DW'(4), 1'b0);
        start = 1'b0;
        run_cycle(base ^ DW'(4), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_checks();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
